// File: rtl/sum_uart_tx.sv
// UART transmitter for the 4-bit adder result: sends the 5-bit sum as two ASCII
// decimal digits (optionally followed by CR LF) as 8N1 frames.
module sum_uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit SEND_CRLF    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sum,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [1:0]        LAST_BYTE = SEND_CRLF ? 2'd3 : 2'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  function automatic logic [3:0] tens_digit(input logic [4:0] v);
    logic [3:0] t;
    if (v >= 5'd30)      t = 4'd3;
    else if (v >= 5'd20) t = 4'd2;
    else if (v >= 5'd10) t = 4'd1;
    else                 t = 4'd0;
    return t;
  endfunction

  function automatic logic [3:0] ones_digit(input logic [4:0] v);
    logic [4:0] t10;
    case (tens_digit(v))
      4'd3:    t10 = 5'd30;
      4'd2:    t10 = 5'd20;
      4'd1:    t10 = 5'd10;
      default: t10 = 5'd0;
    endcase
    return 4'(v - t10);
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_r, bit_s;
  logic [1:0]       byte_r, byte_s;
  logic [4:0]       sum_q_r;
  logic             capture_s;
  logic             tx_r, tx_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [7:0]       cur_byte_s;

  // Character currently on the line, derived from the captured sum.
  always_comb begin
    cur_byte_s = 8'hFF;
    case (byte_r)
      2'd0:    cur_byte_s = digit_char(tens_digit(sum_q_r));
      2'd1:    cur_byte_s = digit_char(ones_digit(sum_q_r));
      2'd2:    cur_byte_s = 8'h0D;
      2'd3:    cur_byte_s = 8'h0A;
      default: cur_byte_s = 8'hFF;
    endcase
  end

  // Next-state logic; output values are computed for the next cycle so they can be registered.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_s     = bit_r;
    byte_s    = byte_r;
    capture_s = 1'b0;
    tx_s      = 1'b1;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (send) begin
          state_s   = START;
          cnt_s     = CNT_ZERO;
          bit_s     = 3'd0;
          byte_s    = 2'd0;
          capture_s = 1'b1;
          tx_s      = 1'b0;
          busy_s    = 1'b1;
        end else begin
          tx_s   = 1'b1;
          busy_s = 1'b0;
        end
      end
      START: begin
        busy_s = 1'b1;
        if (cnt_r == CNT_MAX) begin
          state_s = DATA;
          cnt_s   = CNT_ZERO;
          bit_s   = 3'd0;
          tx_s    = cur_byte_s[0];
        end else begin
          cnt_s = cnt_r + CNT_ONE;
          tx_s  = 1'b0;
        end
      end
      DATA: begin
        busy_s = 1'b1;
        if (cnt_r == CNT_MAX) begin
          cnt_s = CNT_ZERO;
          if (bit_r == 3'd7) begin
            state_s = STOP;
            tx_s    = 1'b1;
          end else begin
            bit_s = bit_r + 3'd1;
            tx_s  = cur_byte_s[bit_r + 3'd1];
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
          tx_s  = cur_byte_s[bit_r];
        end
      end
      STOP: begin
        if (cnt_r == CNT_MAX) begin
          cnt_s = CNT_ZERO;
          if (byte_r == LAST_BYTE) begin
            state_s = IDLE;
            tx_s    = 1'b1;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            // Next start bit follows the stop bit with no idle gap.
            state_s = START;
            byte_s  = byte_r + 2'd1;
            tx_s    = 1'b0;
            busy_s  = 1'b1;
          end
        end else begin
          cnt_s  = cnt_r + CNT_ONE;
          tx_s   = 1'b1;
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        bit_s   = 3'd0;
        byte_s  = 2'd0;
        tx_s    = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counters, captured sum and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= 3'd0;
      byte_r  <= 2'd0;
      sum_q_r <= 5'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      byte_r  <= byte_s;
      if (capture_s) begin
        sum_q_r <= sum;
      end else begin
        sum_q_r <= sum_q_r;
      end
      tx_r   <= tx_s;
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule
